mf_cegen_nco: RTL

- Multi-channel phase-accumulator clock-enable generator running from a single PLL output clock.
- Produces per-channel fractional-rate clock-enable pulses and 50%-duty square levels, e.g. a 12.288 MHz audio enable from the 48.66048 MHz core clock.
- Each channel's rate and phase offset are programmable at run time, and all channels can be phase-realigned together.
- Provides a `locked` indication with the same meaning as a PLL lock: the outputs are stable and free of reconfiguration glitches.

---
 rtl/mf_cegen_nco_if.sv | 27 ++
 rtl/mf_cegen_nco.sv | 76 +++++++
 2 files changed

// File: rtl/mf_cegen_nco_if.sv
// Configuration and output bundle for the multi-channel NCO clock-enable generator.
// The master drives configuration strobes; the slave returns enables, levels and lock.
interface mf_cegen_nco_if #(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = 32
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_wr;
  logic [CH_W-1:0]     cfg_ch;
  logic [ACC_W-1:0]    cfg_inc;
  logic [ACC_W-1:0]    cfg_phase;
  logic                cfg_sync;
  logic [CHANNELS-1:0] ce_out;
  logic [CHANNELS-1:0] level_out;
  logic                locked;

  modport master (
    output cfg_wr, cfg_ch, cfg_inc, cfg_phase, cfg_sync,
    input  ce_out, level_out, locked
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_inc, cfg_phase, cfg_sync,
    output ce_out, level_out, locked
  );
endinterface

// File: rtl/mf_cegen_nco.sv
// Multi-channel phase-accumulator clock-enable generator: per-channel wrap pulses,
// MSB square levels, and a lock flag that asserts after a quiet configuration period.
module mf_cegen_nco #(
  parameter int CHANNELS    = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input logic            refclk,
  input logic            rst,
  mf_cegen_nco_if.slave  bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [ACC_W-1:0]    acc_p0   [CHANNELS];
  logic [ACC_W-1:0]    inc_p0   [CHANNELS];
  logic [ACC_W-1:0]    phase_p0 [CHANNELS];
  logic [CHANNELS-1:0] ce_p0;
  logic [15:0]         lock_cnt;
  logic                locked_p0;
  logic                wr_ok;

  // Accumulator add with the carry kept as the extra top bit.
  function automatic logic [ACC_W:0] wrap_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c >= 16'(LOCK_CYCLES)) ? 16'(LOCK_CYCLES) : c + 16'd1;
  endfunction

  // Writes aimed past the last channel are dropped and do not disturb lock.
  assign wr_ok = bus.cfg_wr && ({1'b0, bus.cfg_ch} < (CH_W + 1)'(CHANNELS));

  // Stage p0: accumulators, enables and lock state, all updated on one edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_p0[i]   <= '0;
        inc_p0[i]   <= '0;
        phase_p0[i] <= '0;
      end
      ce_p0     <= '0;
      lock_cnt  <= '0;
      locked_p0 <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_ok && (bus.cfg_ch == CH_W'(i))) begin
          inc_p0[i]   <= bus.cfg_inc;
          phase_p0[i] <= bus.cfg_phase;
          acc_p0[i]   <= bus.cfg_phase;
          ce_p0[i]    <= 1'b0;
        end else if (bus.cfg_sync) begin
          acc_p0[i] <= phase_p0[i];
          ce_p0[i]  <= 1'b0;
        end else begin
          {ce_p0[i], acc_p0[i]} <= wrap_add(acc_p0[i], inc_p0[i]);
        end
      end
      if (wr_ok || bus.cfg_sync) begin
        lock_cnt  <= '0;
        locked_p0 <= 1'b0;
      end else begin
        lock_cnt  <= sat_inc(lock_cnt);
        locked_p0 <= (sat_inc(lock_cnt) == 16'(LOCK_CYCLES));
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_level
    assign bus.level_out[g] = acc_p0[g][ACC_W-1];
  end

  assign bus.ce_out = ce_p0;
  assign bus.locked = locked_p0;
endmodule
